// File: rtl/comp_serial.sv
// Multi-cycle magnitude comparator: WIDTH-bit operands compared CHUNK bits per clock,
// MSB chunk first, with early exit. Define SIGNED_CMP_EN to add two's-complement mode.
module comp_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SIGNED_CMP_EN
    input  logic             signed_mode,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_gt_B,
    output logic             A_lt_B,
    output logic             A_eq_B
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {IDLE, CMP} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d, sb_q, sb_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               sgn_q, sgn_d;
    logic               done_q, done_d;
    logic [2:0]         flags_q, flags_d;   // {gt, lt, eq}
    logic [CHUNK-1:0]   top_a, top_b;
    logic               last_chunk;

    always_comb begin
        state_d    = state_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        idx_d      = idx_q;
        sgn_d      = sgn_q;
        flags_d    = flags_q;
        done_d     = 1'b0;

        top_a      = sa_q[WIDTH-1 -: CHUNK];
        top_b      = sb_q[WIDTH-1 -: CHUNK];
        // Flipping the sign bit of the top chunk maps two's complement onto unsigned order.
        if (sgn_q && (idx_q == '0)) begin
            top_a[CHUNK-1] = ~top_a[CHUNK-1];
            top_b[CHUNK-1] = ~top_b[CHUNK-1];
        end
        last_chunk = (idx_q == IDX_W'(NCHUNK - 1));

        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = A;
                    sb_d    = B;
                    idx_d   = '0;
`ifdef SIGNED_CMP_EN
                    sgn_d   = signed_mode;
`else
                    sgn_d   = 1'b0;
`endif
                    state_d = CMP;
                end
            end
            CMP: begin
                if (top_a > top_b) begin
                    flags_d = 3'b100;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (top_a < top_b) begin
                    flags_d = 3'b010;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (last_chunk) begin
                    flags_d = 3'b001;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    sa_d    = sa_q << CHUNK;
                    sb_d    = sb_q << CHUNK;
                    idx_d   = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: operand shift registers are reset along with control state so an aborted
    // compare leaves no stale data behind; they are small enough that this costs little.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            idx_q   <= '0;
            sgn_q   <= 1'b0;
            done_q  <= 1'b0;
            flags_q <= 3'b000;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            idx_q   <= idx_d;
            sgn_q   <= sgn_d;
            done_q  <= done_d;
            flags_q <= flags_d;
        end
    end

    assign busy   = (state_q == CMP);
    assign done   = done_q;
    assign A_gt_B = flags_q[2];
    assign A_lt_B = flags_q[1];
    assign A_eq_B = flags_q[0];

endmodule

// File: tb/tb_comp_serial.sv
// Randomized self-checking bench for comp_serial against an arithmetic reference model.
module tb_comp_serial;

    localparam int W   = 16;
    localparam int C   = 4;
    localparam int NCH = W / C;
`ifdef SIGNED_CMP_EN
    localparam bit HAS_SIGNED = 1'b1;
`else
    localparam bit HAS_SIGNED = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         signed_mode = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, A_gt_B, A_lt_B, A_eq_B;

    int n_checks = 0;
    int n_fail   = 0;

    comp_serial #(.WIDTH(W), .CHUNK(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
`ifdef SIGNED_CMP_EN
        .signed_mode(signed_mode),
`endif
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .A_gt_B     (A_gt_B),
        .A_lt_B     (A_lt_B),
        .A_eq_B     (A_eq_B)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] flags();
        return {A_gt_B, A_lt_B, A_eq_B};
    endfunction

    // Result from plain integer compare; latency from index of the first differing chunk.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm,
                         output logic [2:0] f, output int lat);
        int ia, ib;
        if (sm && HAS_SIGNED) begin
            ia = int'($signed(a));
            ib = int'($signed(b));
        end else begin
            ia = int'({16'h0, a});
            ib = int'({16'h0, b});
        end
        f   = (ia > ib) ? 3'b100 : (ia < ib) ? 3'b010 : 3'b001;
        lat = NCH;
        for (int k = 0; k < NCH; k++) begin
            if (((a >> (W - C * (k + 1))) & 16'hF) != ((b >> (W - C * (k + 1))) & 16'hF)) begin
                lat = k + 1;
                break;
            end
        end
    endtask

    // Called #1 after a posedge with the DUT idle. poke pulses start mid-compare.
    task automatic do_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm, input bit poke);
        logic [2:0] exp_f, prev_f;
        int         lat, edges;
        bit         got;
        model(a, b, sm, exp_f, lat);
        prev_f      = flags();
        A           = a;
        B           = b;
        signed_mode = sm;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_accept", busy, 1);
        check("done_after_accept", done, 0);
        edges = 0;
        got   = 1'b0;
        while (!got && edges < NCH + 4) begin
            if (poke && edges == 1) begin
                start = 1'b1;
                A     = ~a;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
            if (done) got = 1'b1;
            else      check("flags_hold_busy", flags(), prev_f);
        end
        start = 1'b0;
        check("done_seen", got, 1);
        check("latency", edges, lat);
        check("result", flags(), exp_f);
        check("busy_clear", busy, 0);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("busy_stays_idle", busy, 0);
        check("flags_hold_idle", flags(), exp_f);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [2:0]   ef;
        int           lat, edges;
        bit           got, seen;

        // Reset state, with start asserted to show it is ignored under reset.
        start = 1'b1;
        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_flags", flags(), 3'b000);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy_held", busy, 0);
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk); #1;

        do_cmp(16'h0000, 16'h0000, 1'b0, 1'b0);
        do_cmp(16'hF000, 16'h0FFF, 1'b0, 1'b0);
        do_cmp(16'h1233, 16'h1234, 1'b0, 1'b1);
        do_cmp(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        do_cmp(16'h0000, 16'hFFFF, 1'b0, 1'b0);
        do_cmp(16'hFFFF, 16'h0001, 1'b1, 1'b0);
        do_cmp(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        do_cmp(16'h8000, 16'h7FFF, 1'b1, 1'b0);

        // Back-to-back: start held through the done cycle.
        A     = 16'h1233;
        B     = 16'h1234;
        start = 1'b1;
        @(posedge clk); #1;
        A = 16'h00FF;
        B = 16'h00FE;
        signed_mode = 1'b0;
        got   = 1'b0;
        edges = 0;
        while (!got && edges < NCH + 4) begin
            @(posedge clk); #1;
            edges++;
            got = done;
        end
        check("b2b_first_latency", edges, 4);
        check("b2b_first_result", flags(), 3'b010);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_second_accepted", busy, 1);
        check("b2b_prev_flags_held", flags(), 3'b010);
        got   = 1'b0;
        edges = 0;
        while (!got && edges < NCH + 4) begin
            @(posedge clk); #1;
            edges++;
            if (done) got = 1'b1;
            else      check("b2b_flags_hold", flags(), 3'b010);
        end
        check("b2b_second_latency", edges, 4);
        check("b2b_second_result", flags(), 3'b100);
        @(posedge clk); #1;

        // Asynchronous reset during the second CMP cycle.
        A     = 16'h1233;
        B     = 16'h1234;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_flags", flags(), 3'b000);
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);

        // Random compares biased towards shared leading chunks.
        for (int t = 0; t < 300; t++) begin
            int k;
            ra = W'($urandom);
            k  = int'($urandom_range(0, NCH));
            rb = ra;
            if (k < NCH) begin
                logic [W-1:0] m;
                m  = 16'hF << (W - C * (k + 1));
                rb = (ra & ~m) | (W'($urandom) & m);
                if ($urandom_range(0, 3) == 0) rb = W'($urandom);
            end
            do_cmp(ra, rb, 1'(($urandom) & 1), 1'b0);
        end

        // Model sanity against itself is avoided; one final direct equal compare.
        model(16'hA5A5, 16'hA5A5, 1'b0, ef, lat);
        do_cmp(16'hA5A5, 16'hA5A5, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
